// File: rtl/param_johnson_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : param_johnson_counter_if
// Description : Control/status bundle for param_johnson_counter. The master
//               drives the step controls and load data; the slave (the
//               counter) returns the registered state and its decodes.
// Revision    : 1.0 - initial release
// ============================================================================
interface param_johnson_counter_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(2 * WIDTH);

  logic             en;
  logic             mode;
  logic             dir;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_bar;
  logic [PW-1:0]    phase;
  logic             legal;
  logic             wrap;

  modport master (
    output en, mode, dir, load, load_val,
    input  count, count_bar, phase, legal, wrap
  );

  modport slave (
    input  en, mode, dir, load, load_val,
    output count, count_bar, phase, legal, wrap
  );
endinterface
`default_nettype wire

// File: rtl/param_johnson_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_johnson_counter
// Description : Parametrised twisted-ring counter. Runs a WIDTH-bit Johnson
//               sequence (2*WIDTH states) or a one-hot ring sequence (WIDTH
//               states), selectable at run time, with up/down stepping,
//               count enable, synchronous parallel load, decoded phase index,
//               legality flag and a registered wrap pulse.
//               Optional macro JOHNSON_SELF_CORRECT_EN: when defined, an
//               illegal state is forced back to the current mode's seed on
//               the next edge (unless a load or mode change takes priority).
// Revision    : 1.0 - initial release
// ============================================================================
module param_johnson_counter #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,   // asynchronous, active-low
  param_johnson_counter_if.slave bus
);

  localparam int PW = $clog2(2 * WIDTH);

  localparam logic [WIDTH-1:0] c_JOHNSON_SEED = '0;
  localparam logic [WIDTH-1:0] c_RING_SEED    = WIDTH'(1);
  localparam logic [PW:0]      c_TWO_W        = (PW + 1)'(2 * WIDTH);
  localparam logic [PW-1:0]    c_LAST_JOHNSON = PW'(2 * WIDTH - 1);
  localparam logic [PW-1:0]    c_LAST_RING    = PW'(WIDTH - 1);

  // Registered state
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_count_bar;
  logic             r_wrap;
  logic             r_mode_q;

  // Decode and next-state wires
  logic [WIDTH-1:0] w_inv;
  logic             w_therm_lo;
  logic             w_therm_hi;
  logic             w_onehot;
  logic             w_legal;
  logic [PW:0]      w_pop;
  logic [PW-1:0]    w_ring_idx;
  logic [PW-1:0]    w_phase;
  logic [PW-1:0]    w_last;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH-1:0] w_count_next;
  logic             w_wrap_next;

  // Legality: Johnson states are thermometer codes filled from either end
  // (x & (x+1) == 0 detects 0..01..1); ring states have exactly one bit set.
  assign w_inv      = ~r_count;
  assign w_therm_lo = ((r_count & (r_count + WIDTH'(1))) == '0);
  assign w_therm_hi = ((w_inv & (w_inv + WIDTH'(1))) == '0);
  assign w_onehot   = (r_count != '0) &&
                      ((r_count & (r_count - WIDTH'(1))) == '0);
  assign w_legal    = r_mode_q ? w_onehot : (w_therm_lo || w_therm_hi);

  // Population count and highest set-bit index feed the phase decoder
  always_comb begin
    w_pop      = '0;
    w_ring_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + (PW + 1)'(r_count[i]);
      if (r_count[i]) begin
        w_ring_idx = PW'(i);
      end
    end
  end

  // Phase index: the filling half of the Johnson cycle counts ones, the
  // draining half (MSB set) counts down from 2W; illegal states report 0
  always_comb begin
    w_phase = '0;
    if (w_legal) begin
      if (r_mode_q) begin
        w_phase = w_ring_idx;
      end else if (!r_count[WIDTH-1]) begin
        w_phase = w_pop[PW-1:0];
      end else begin
        w_phase = PW'(c_TWO_W - w_pop);
      end
    end
  end

  assign w_last = r_mode_q ? c_LAST_RING : c_LAST_JOHNSON;

  // One shift step in the running mode and requested direction
  always_comb begin
    w_shift = r_count;
    case ({r_mode_q, bus.dir})
      2'b00:   w_shift = {r_count[WIDTH-2:0], ~r_count[WIDTH-1]};
      2'b01:   w_shift = {~r_count[0], r_count[WIDTH-1:1]};
      2'b10:   w_shift = {r_count[WIDTH-2:0], r_count[WIDTH-1]};
      default: w_shift = {r_count[0], r_count[WIDTH-1:1]};
    endcase
    // An empty ring would circulate zero forever; re-inject the seed bit
    if (r_mode_q && (r_count == '0)) begin
      w_shift = c_RING_SEED;
    end
  end

  // Per-edge priority: load, mode change, optional correction, step, hold.
  // Wrap fires only on a real step across the last/first phase boundary.
  always_comb begin
    w_count_next = r_count;
    w_wrap_next  = 1'b0;
    if (bus.load) begin
      w_count_next = bus.load_val;
    end else if (bus.mode != r_mode_q) begin
      w_count_next = bus.mode ? c_RING_SEED : c_JOHNSON_SEED;
`ifdef JOHNSON_SELF_CORRECT_EN
    end else if (!w_legal) begin
      w_count_next = r_mode_q ? c_RING_SEED : c_JOHNSON_SEED;
`endif
    end else if (bus.en) begin
      w_count_next = w_shift;
      w_wrap_next  = w_legal && (bus.dir ? (w_phase == '0)
                                         : (w_phase == w_last));
    end
  end

  // State registers; count_bar is loaded from the same next value as count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_count_bar <= '1;
      r_wrap      <= 1'b0;
      r_mode_q    <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_count_bar <= ~w_count_next;
      r_wrap      <= w_wrap_next;
      r_mode_q    <= bus.mode;
    end
  end

  assign bus.count     = r_count;
  assign bus.count_bar = r_count_bar;
  assign bus.phase     = w_phase;
  assign bus.legal     = w_legal;
  assign bus.wrap      = r_wrap;

endmodule
`default_nettype wire
